// File: rtl/flaf_ctrl_pkg.sv
// Shared types and constants for the tap scheduler: FSM state encoding and
// the width of a delay-line index.
package flaf_ctrl_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_e;

    localparam int TAPS_DEFAULT = 8;
    localparam int TAP_IDX_W    = $clog2(TAPS_DEFAULT);

    // Index width for an arbitrary delay-line length; never narrower than one bit.
    function automatic int idx_width(input int taps);
        return (taps > 1) ? $clog2(taps) : 1;
    endfunction

endpackage

// File: rtl/tap_sched_if.sv
// Sample-in / tap-out handshake bundle between the scheduler and its neighbours.
interface tap_sched_if
    import flaf_ctrl_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int TAPS  = TAPS_DEFAULT
);
    localparam int IW = idx_width(TAPS);

    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] tap_data;
    logic [IW-1:0]    tap_idx;
    logic             tap_valid;
    logic             tap_last;
    logic             tap_ready;
    logic             primed;

    modport master (
        output in_data, in_valid, tap_ready,
        input  in_ready, tap_data, tap_idx, tap_valid, tap_last, primed
    );

    modport slave (
        input  in_data, in_valid, tap_ready,
        output in_ready, tap_data, tap_idx, tap_valid, tap_last, primed
    );

endinterface

// File: rtl/tap_buffer.sv
// TAPS x WIDTH delay-line register file: one write port, one combinational
// read port, synchronous clear of every entry.
module tap_buffer
    import flaf_ctrl_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int TAPS  = TAPS_DEFAULT,
    parameter int AW    = idx_width(TAPS)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [TAPS];

    // Clearing every entry is what makes never-written taps read back as zero.
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < TAPS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/tap_sched.sv
// Delay-line tap scheduler: accepts one sample, then streams all TAPS delayed
// samples (newest first) to a shared downstream multiplier.
module tap_sched
    import flaf_ctrl_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int TAPS  = TAPS_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    tap_sched_if.slave  bus
);

    localparam int             IW       = idx_width(TAPS);
    localparam int             FW       = IW + 1;
    localparam logic [FW-1:0]  FILL_MAX = FW'(TAPS);
    localparam logic [IW-1:0]  IDX_LAST = IW'(TAPS - 1);

    state_e          state_q, state_d;
    logic [IW-1:0]   wp_q, wp_d;
    logic [IW-1:0]   base_q, base_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [FW-1:0]   fill_q, fill_d;

    logic             clr;
    logic             is_stream;
    logic             accept;
    logic             xfer;
    logic             at_last;
    logic             tap_vld;
    logic [IW-1:0]    rd_addr;
    logic [WIDTH-1:0] rd_data;

    assign clr       = reset | flush;
    assign is_stream = (state_q == STREAM);
    assign accept    = ~is_stream & ~clr & bus.in_valid;
    assign xfer      = is_stream & bus.tap_ready;
    assign at_last   = (idx_q == IDX_LAST);
    // TAPS is a power of two, so plain IW-bit subtraction wraps modulo TAPS.
    assign rd_addr   = base_q - idx_q;

    always_comb begin
        state_d = state_q;
        wp_d    = wp_q;
        base_d  = base_q;
        idx_d   = idx_q;
        fill_d  = fill_q;
        if (clr) begin
            state_d = IDLE;
            wp_d    = '0;
            base_d  = '0;
            idx_d   = '0;
            fill_d  = '0;
        end else if (accept) begin
            base_d  = wp_q;
            wp_d    = wp_q + 1'b1;
            idx_d   = '0;
            fill_d  = (fill_q == FILL_MAX) ? fill_q : fill_q + 1'b1;
            state_d = STREAM;
        end else if (xfer) begin
            idx_d = idx_q + 1'b1;
            if (at_last) begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            wp_q    <= '0;
            base_q  <= '0;
            idx_q   <= '0;
            fill_q  <= '0;
        end else begin
            state_q <= state_d;
            wp_q    <= wp_d;
            base_q  <= base_d;
            idx_q   <= idx_d;
            fill_q  <= fill_d;
        end
    end

    tap_buffer #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .AW    (IW)
    ) u_buf (
        .clk   (clk),
        .clr   (clr),
        .we    (accept),
        .waddr (wp_q),
        .wdata (bus.in_data),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    // Reset gates outputs combinationally so they read zero during the reset cycle itself.
    assign tap_vld       = is_stream & ~reset;
    assign bus.in_ready  = ~is_stream & ~clr;
    assign bus.tap_valid = tap_vld;
    assign bus.tap_last  = tap_vld & at_last;
    assign bus.tap_idx   = tap_vld ? idx_q : '0;
    assign bus.tap_data  = tap_vld ? rd_data : '0;
    assign bus.primed    = ~reset & (fill_q == FILL_MAX);

endmodule
